data_ram_responder: RTL and testbench

Responder-side data memory for the pipelined CPU's MEM stage. It accepts one load or store request at a time on a request/ready handshake and models a memory with a configurable multi-cycle access latency. While an access is in flight it drives a stall toward the pipeline. It replaces the single-cycle data RAM when the core is built against slow memory.

---
 rtl/data_ram_responder.sv | 118 +++++++++++
 tb/tb_data_ram_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Multi-cycle data memory responder for the MEM stage: one load/store in flight,
// completion signalled by a one-cycle ready pulse after LATENCY cycles.
module data_ram_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] din_i,
    output logic [31:0] dout_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);
    localparam int         WORDS      = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [0:WORDS-1];

    logic [1:0]            state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic                  isStore_q, isStore_d;
    logic                  misaligned_q, misaligned_d;
    logic [ADDR_WIDTH-1:0] wordAddr_q, wordAddr_d;
    logic [31:0]           storeData_q, storeData_d;
    logic [31:0]           dout_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  commit;
    logic                  unusedAddrBits;

    // Bits above the word index only alias the same storage, so they are dropped.
    assign unusedAddrBits = ^addr_i[31:ADDR_WIDTH+2];

    // The _d copy of the request is the live input in IDLE and the captured copy
    // afterwards, so the commit logic never has to care which state it came from.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        isStore_d    = isStore_q;
        misaligned_d = misaligned_q;
        wordAddr_d   = wordAddr_q;
        storeData_d  = storeData_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    isStore_d    = we_i;
                    misaligned_d = (addr_i[1:0] != 2'b00);
                    wordAddr_d   = addr_i[ADDR_WIDTH+1:2];
                    storeData_d  = din_i;
                    count_d      = LOAD_COUNT;
                    state_d      = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset on the commit edge must cancel the access, including the store.
    assign commit = (state_d == RESP) && (state_q != RESP) && !reset_i;

    always_ff @(posedge clk_i) begin
        if (commit && isStore_d && !misaligned_d) begin
            mem[wordAddr_d] <= storeData_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            isStore_q    <= 1'b0;
            misaligned_q <= 1'b0;
            wordAddr_q   <= '0;
            storeData_q  <= 32'd0;
            dout_q       <= 32'd0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            isStore_q    <= isStore_d;
            misaligned_q <= misaligned_d;
            wordAddr_q   <= wordAddr_d;
            storeData_q  <= storeData_d;
            ready_q      <= commit;
            err_q        <= commit && misaligned_d;
            if (commit && !isStore_d && !misaligned_d) begin
                dout_q <= mem[wordAddr_d];
            end
        end
    end

    assign dout_o  = dout_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign stall_o = req_i && !ready_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized self-checking bench: three responders (LATENCY 1, 2, 4) against a
// word-array reference model that resolves each access at acceptance time.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] din   [3];
    logic [31:0] dout  [3];
    logic        ready [3];
    logic        err   [3];
    logic        stall [3];

    int          checkCount = 0;
    int          failCount  = 0;
    int          cyc        = 0;

    logic [31:0] modelMem  [3][256];
    logic [31:0] modelDout [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_ram_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dutLat1 (
        .clk_i(clk), .reset_i(reset[0]), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .din_i(din[0]), .dout_o(dout[0]), .ready_o(ready[0]),
        .err_o(err[0]), .stall_o(stall[0])
    );

    data_ram_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dutLat2 (
        .clk_i(clk), .reset_i(reset[1]), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .din_i(din[1]), .dout_o(dout[1]), .ready_o(ready[1]),
        .err_o(err[1]), .stall_o(stall[1])
    );

    data_ram_responder #(.ADDR_WIDTH(8), .LATENCY(4)) dutLat4 (
        .clk_i(clk), .reset_i(reset[2]), .req_i(req[2]), .we_i(we[2]),
        .addr_i(addr[2]), .din_i(din[2]), .dout_o(dout[2]), .ready_o(ready[2]),
        .err_o(err[2]), .stall_o(stall[2])
    );

    function automatic int latOf(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic string tg(input string name, input int i);
        return $sformatf("%s[L%0d]", name, latOf(i));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One access: driven at a negedge in IDLE, watched until ready (bounded),
    // then one cycle later checked for a single-cycle pulse.
    task automatic applyStimulus(input int i, input bit w, input logic [31:0] a,
                                 input logic [31:0] d, input bit dropReq,
                                 input bit keepReq, output int readyCyc);
        int lat;
        int c;
        bit seen;
        bit mis;
        int widx;
        lat = latOf(i);
        req[i]  = 1'b1;
        we[i]   = w;
        addr[i] = a;
        din[i]  = d;
        #1;
        checkOutput(tg("stallReq", i), 32'(stall[i]), 32'd1);
        mis  = (a[1:0] != 2'b00);
        widx = int'(a[9:2]);
        if (!mis) begin
            if (w) modelMem[i][widx] = d;
            else   modelDout[i] = modelMem[i][widx];
        end
        @(posedge clk);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < lat + 4) begin
            @(negedge clk);
            c++;
            if (dropReq && c == 1) begin
                req[i] = 1'b0;
                #1;
            end
            if (ready[i] === 1'b1) seen = 1'b1;
            else checkOutput(tg("stallBusy", i), 32'(stall[i]), 32'(!dropReq));
        end
        readyCyc = cyc;
        checkOutput(tg("readyLatency", i), 32'(c), 32'(lat));
        checkOutput(tg("errFlag", i), 32'(err[i]), 32'(mis));
        checkOutput(tg("stallAtReady", i), 32'(stall[i]), 32'd0);
        checkOutput(tg("doutValue", i), dout[i], modelDout[i]);
        @(posedge clk);
        @(negedge clk);
        checkOutput(tg("readyOnePulse", i), 32'(ready[i]), 32'd0);
        if (!keepReq) begin
            req[i] = 1'b0;
            #1;
            checkOutput(tg("stallIdle", i), 32'(stall[i]), 32'd0);
        end
    endtask

    // Accept a store, then assert reset `resetAt` cycles after acceptance.
    task automatic abortedStore(input int i, input logic [31:0] a, input logic [31:0] d,
                                input int resetAt);
        bit sawReady;
        req[i]  = 1'b1;
        we[i]   = 1'b1;
        addr[i] = a;
        din[i]  = d;
        @(posedge clk);
        for (int k = 1; k <= resetAt; k++) @(negedge clk);
        reset[i] = 1'b1;
        req[i]   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset[i]     = 1'b0;
        modelDout[i] = 32'd0;
        #1;
        checkOutput(tg("doutAfterReset", i), dout[i], 32'd0);
        checkOutput(tg("stallAfterReset", i), 32'(stall[i]), 32'd0);
        sawReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (ready[i] === 1'b1) sawReady = 1'b1;
            @(negedge clk);
        end
        checkOutput(tg("noReadyAfterAbort", i), 32'(sawReady), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        int r1;
        int rc;
        bit w;
        bit drop;
        bit keep;
        logic [31:0] a;
        logic [31:0] d;

        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1;
            req[i]   = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = 32'd0;
            din[i]   = 32'd0;
            modelDout[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput(tg("resetDout", i), dout[i], 32'd0);
            checkOutput(tg("resetReady", i), 32'(ready[i]), 32'd0);
            checkOutput(tg("resetErr", i), 32'(err[i]), 32'd0);
            checkOutput(tg("resetStall", i), 32'(stall[i]), 32'd0);
            reset[i] = 1'b0;
        end
        @(negedge clk);

        $display("[TB] store/load at LATENCY 2");
        applyStimulus(1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, rc);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rc);

        $display("[TB] back-to-back at LATENCY 1");
        applyStimulus(0, 1'b1, 32'h0, 32'd1, 1'b0, 1'b1, r0);
        applyStimulus(0, 1'b1, 32'h4, 32'd2, 1'b0, 1'b1, r1);
        checkOutput("b2bSpacing1[L1]", 32'(r1 - r0), 32'd2);
        applyStimulus(0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, r0);
        checkOutput("b2bSpacing2[L1]", 32'(r0 - r1), 32'd2);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, r1);
        checkOutput("b2bSpacing3[L1]", 32'(r1 - r0), 32'd2);

        $display("[TB] misaligned and wrap");
        applyStimulus(1, 1'b1, 32'h13, 32'h0BADF00D, 1'b0, 1'b0, rc);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, rc);
        applyStimulus(1, 1'b0, 32'h12, 32'h0, 1'b0, 1'b0, rc);
        applyStimulus(1, 1'b1, 32'h404, 32'hCAFEF00D, 1'b0, 1'b0, rc);
        applyStimulus(1, 1'b0, 32'h004, 32'h0, 1'b0, 1'b0, rc);

        $display("[TB] reset mid-access at LATENCY 4");
        applyStimulus(2, 1'b1, 32'h20, 32'h11112222, 1'b0, 1'b0, rc);
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, rc);
        abortedStore(2, 32'h20, 32'h55, 2);
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, rc);

        $display("[TB] reset on the commit edge at LATENCY 2");
        applyStimulus(1, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 1'b0, rc);
        abortedStore(1, 32'h30, 32'h99, 1);
        applyStimulus(1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, rc);

        $display("[TB] request withdrawn while busy");
        applyStimulus(2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, rc);
        applyStimulus(1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, rc);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) begin
                applyStimulus(i, 1'b1, 32'h40 + 32'(4 * k), $urandom, 1'b0, 1'b0, rc);
            end
            for (int n = 0; n < 30; n++) begin
                w = 1'($urandom_range(0, 1));
                a = 32'h40 + 32'(4 * $urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 255)) << 10);
                d    = $urandom;
                drop = (latOf(i) > 1) && ($urandom_range(0, 5) == 0);
                keep = 1'($urandom_range(0, 1));
                applyStimulus(i, w, a, d, drop, keep, rc);
            end
            req[i] = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
